// File: rtl/bg_image_writer_pkg.sv
// Shared video constants and the background writer state encoding.
// The background reader and the frame memory use the same widths.
package bg_image_writer_pkg;

    localparam int PIXEL_BITS = 12;
    localparam int ADDR_BITS  = 19;
    localparam int COL_BITS   = 10;
    localparam int ROW_BITS   = 9;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wr_state_t;

endpackage

// File: rtl/bg_image_writer_if.sv
// Pixel stream in, frame-memory write port out.
// The slave modport is the writer's view; master is the source/memory side.
interface bg_image_writer_if
    import bg_image_writer_pkg::*;
#(
    parameter int AW = ADDR_BITS,
    parameter int PW = PIXEL_BITS
);

    logic          pix_valid;
    logic [PW-1:0] pix_data;
    logic          pix_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [PW-1:0] wdata;

    modport master (
        output pix_valid, pix_data,
        input  pix_ready, we, waddr, wdata
    );

    modport slave (
        input  pix_valid, pix_data,
        output pix_ready, we, waddr, wdata
    );

endinterface

// File: rtl/bg_image_writer.sv
// Streams one pixel per accepted beat into frame memory in row-major order
// starting at a latched base address; pulses done after the last write.
module bg_image_writer
    import bg_image_writer_pkg::*;
#(
    parameter int memory_depth_base = ADDR_BITS,
    parameter int pixel_bits        = PIXEL_BITS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [COL_BITS-1:0]          width,
    input  logic [ROW_BITS-1:0]          height,
    input  logic [memory_depth_base-1:0] memory_start_addr,
    output logic                         busy,
    output logic                         done,
    bg_image_writer_if.slave             bus
);

    wr_state_t state, state_next;

    logic [COL_BITS-1:0]          width_q;
    logic [ROW_BITS-1:0]          height_q;
    logic [memory_depth_base-1:0] base_q;
    logic [COL_BITS-1:0]          col;
    logic [ROW_BITS-1:0]          row;
    logic [memory_depth_base-1:0] offset;
    logic                         we_q;
    logic [memory_depth_base-1:0] waddr_q;
    logic [pixel_bits-1:0]        wdata_q;

    logic transfer;
    logic col_last;
    logic last_beat;
    logic zero_size;

    assign transfer  = (state == WRITE) && bus.pix_valid;
    assign col_last  = (col == width_q - COL_BITS'(1));
    assign last_beat = transfer && col_last && (row == height_q - ROW_BITS'(1));
    assign zero_size = (width == '0) || (height == '0);

    assign bus.pix_ready = (state == WRITE);
    assign busy          = (state == WRITE);
    assign bus.we        = we_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && !zero_size) state_next = WRITE;
            WRITE:   if (last_beat)           state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Geometry is latched only in IDLE so a start during a load cannot disturb it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            width_q  <= '0;
            height_q <= '0;
            base_q   <= '0;
            col      <= '0;
            row      <= '0;
            offset   <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            done     <= 1'b0;
        end else begin
            we_q <= 1'b0;
            done <= 1'b0;
            if (state == IDLE && start) begin
                width_q  <= width;
                height_q <= height;
                base_q   <= memory_start_addr;
                col      <= '0;
                row      <= '0;
                offset   <= '0;
                done     <= zero_size;
            end
            if (transfer) begin
                we_q    <= 1'b1;
                wdata_q <= bus.pix_data;
                waddr_q <= base_q + offset;
                offset  <= offset + memory_depth_base'(1);
                if (col_last) begin
                    col <= '0;
                    row <= row + ROW_BITS'(1);
                end else begin
                    col <= col + COL_BITS'(1);
                end
                done <= last_beat;
            end
        end
    end

endmodule
